// File: rtl/regfile_pkg.sv
// Shared register-file constants used by decode, issue and the register file itself.
package regfile_pkg;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register pending bits with set-over-clear priority and a registered population count.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned N_WR     = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_en_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
  input  logic [N_WR-1:0]          wr_en_i,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr_i,
  output logic [(1<<ADDR_W)-1:0]   pend_o,
  output logic [ADDR_W:0]          pend_cnt_o
);
  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  // Clears are applied first so a same-edge alloc overrides a retiring write.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned j = 0; j < N_WR; j++) begin
      if (wr_en_i[j]) pend_d[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_en_i) pend_d[alloc_addr_i] = 1'b1;
    if (ZERO_REG != 0) pend_d[ZA] = 1'b0;
    cnt_d = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(pend_d[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: async reads with optional bypass, sync writes, pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned N_WR     = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic [N_RD-1:0]        rd_busy,
  input  logic [N_WR-1:0]        wr_en,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [ADDR_W-1:0]      alloc_addr,
  output logic [ADDR_W:0]        pend_cnt
);
  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  logic [NREGS-1:0]  pend;

  // Ascending port order makes the highest-indexed port win on an address conflict.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < N_WR; j++) begin
      if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == ZA))
        mem_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NREGS; k++) mem_q[k] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .N_WR     (N_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .pend_o       (pend),
    .pend_cnt_o   (pend_cnt)
  );

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              hit, busy;

    assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = mem_q[ra];
      hit  = 1'b0;
      for (int unsigned j = 0; j < N_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ra) begin
          hit = 1'b1;
          if (BYPASS != 0) rdat = wr_data[j*DATA_W +: DATA_W];
        end
      end
      busy = pend[ra];
      // A retiring write hides busy early unless a new producer claims the register.
      if (BYPASS != 0 && hit && !(alloc_en && alloc_addr == ra)) busy = 1'b0;
      if (ZERO_REG != 0 && ra == ZA) begin
        rdat = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[gi*DATA_W +: DATA_W] = rdat;
    assign rd_busy[gi]                  = busy;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: instance A (bypass, two write ports), instance B (no bypass, one write port).
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [1:0]  a_wr_en;
  logic [9:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic        a_alloc_en;
  logic [4:0]  a_alloc_addr;
  logic [5:0]  a_pend_cnt;

  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_alloc_en;
  logic [4:0]  b_alloc_addr;
  logic [5:0]  b_pend_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp #(.N_WR(2)) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .pend_cnt(a_pend_cnt)
  );

  regfile_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .pend_cnt(b_pend_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    a_wr_en = '0; a_alloc_en = 1'b0;
    b_wr_en = '0; b_alloc_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_alloc_en = 1'b0; a_alloc_addr = '0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_alloc_en = 1'b0; b_alloc_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    a_rd_addr = {5'd31, 5'd5};
    #1;
    check_eq("reset_rd_data", a_rd_data, 64'h0);
    check_eq("reset_rd_busy", {62'h0, a_rd_busy}, 64'h0);
    check_eq("reset_pend_cnt", {58'h0, a_pend_cnt}, 64'h0);

    // r3 = DEADBEEF plus a pending r12, then async reset between edges
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd3; a_wr_data[31:0] = 32'hDEADBEEF;
    a_alloc_en = 1'b1; a_alloc_addr = 5'd12;
    step();
    a_rd_addr[4:0] = 5'd3;
    #1;
    check_eq("r3_written", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
    check_eq("r12_pend_cnt", {58'h0, a_pend_cnt}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("midcycle_rst_r3", {32'h0, a_rd_data[31:0]}, 64'h0);
    check_eq("midcycle_rst_cnt", {58'h0, a_pend_cnt}, 64'h0);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd3; a_wr_data[31:0] = 32'hCAFE;
    a_alloc_en = 1'b1; a_alloc_addr = 5'd3;
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_drops_write", {32'h0, a_rd_data[31:0]}, 64'h0);
    check_eq("rst_drops_alloc", {58'h0, a_pend_cnt}, 64'h0);

    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd7; a_wr_data[31:0] = 32'h12345678;
    step();
    a_rd_addr[4:0] = 5'd7;
    #1 check_eq("r7_read", {32'h0, a_rd_data[31:0]}, 64'h12345678);

    a_rd_addr[4:0] = 5'd0;
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd0; a_wr_data[31:0] = 32'hFFFFFFFF;
    #1 check_eq("r0_no_bypass", {32'h0, a_rd_data[31:0]}, 64'h0);
    step();
    check_eq("r0_after_write", {32'h0, a_rd_data[31:0]}, 64'h0);
    a_alloc_en = 1'b1; a_alloc_addr = 5'd0;
    step();
    check_eq("r0_alloc_cnt", {58'h0, a_pend_cnt}, 64'h0);
    check_eq("r0_busy", {63'h0, a_rd_busy[0]}, 64'h0);

    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd9; a_wr_data[31:0] = 32'hA5A5A5A5;
    a_rd_addr[9:5] = 5'd9;
    b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_data = 32'hA5A5A5A5;
    b_rd_addr[4:0] = 5'd9;
    #1;
    check_eq("bypass_same_cycle", {32'h0, a_rd_data[63:32]}, 64'hA5A5A5A5);
    check_eq("nobypass_old", {32'h0, b_rd_data[31:0]}, 64'h0);
    step();
    check_eq("nobypass_new", {32'h0, b_rd_data[31:0]}, 64'hA5A5A5A5);
    check_eq("bypass_stored", {32'h0, a_rd_data[63:32]}, 64'hA5A5A5A5);

    a_wr_en = 2'b11; a_wr_addr = {5'd4, 5'd4};
    a_wr_data = {32'h2222, 32'h1111};
    a_rd_addr[4:0] = 5'd4;
    #1 check_eq("dual_bypass", {32'h0, a_rd_data[31:0]}, 64'h2222);
    step();
    check_eq("dual_conflict", {32'h0, a_rd_data[31:0]}, 64'h2222);

    a_alloc_en = 1'b1; a_alloc_addr = 5'd10;
    step();
    a_rd_addr[4:0] = 5'd10;
    #1;
    check_eq("alloc_busy", {63'h0, a_rd_busy[0]}, 64'd1);
    check_eq("alloc_cnt", {58'h0, a_pend_cnt}, 64'd1);
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd10; a_wr_data[31:0] = 32'h55;
    #1 check_eq("clear_mask_busy", {63'h0, a_rd_busy[0]}, 64'h0);
    step();
    check_eq("clear_busy", {63'h0, a_rd_busy[0]}, 64'h0);
    check_eq("clear_cnt", {58'h0, a_pend_cnt}, 64'h0);
    check_eq("clear_data", {32'h0, a_rd_data[31:0]}, 64'h55);
    a_alloc_en = 1'b1; a_alloc_addr = 5'd10;
    a_wr_en = 2'b01; a_wr_addr[4:0] = 5'd10; a_wr_data[31:0] = 32'h66;
    step();
    check_eq("setwins_data", {32'h0, a_rd_data[31:0]}, 64'h66);
    check_eq("setwins_busy", {63'h0, a_rd_busy[0]}, 64'd1);
    check_eq("setwins_cnt", {58'h0, a_pend_cnt}, 64'd1);
    a_wr_en = 2'b10; a_wr_addr[9:5] = 5'd10; a_wr_data[63:32] = 32'h77;
    step();
    check_eq("port1_clear_cnt", {58'h0, a_pend_cnt}, 64'h0);

    b_alloc_en = 1'b1; b_alloc_addr = 5'd10;
    step();
    b_rd_addr[4:0] = 5'd10;
    b_wr_en = 1'b1; b_wr_addr = 5'd10; b_wr_data = 32'h55;
    #1;
    check_eq("b_busy_unmasked", {63'h0, b_rd_busy[0]}, 64'd1);
    check_eq("b_cnt_alloc", {58'h0, b_pend_cnt}, 64'd1);
    step();
    check_eq("b_busy_cleared", {63'h0, b_rd_busy[0]}, 64'h0);
    check_eq("b_cnt_cleared", {58'h0, b_pend_cnt}, 64'h0);

    for (int r = 1; r < 32; r++) begin
      a_alloc_en = 1'b1; a_alloc_addr = 5'(r);
      step();
    end
    check_eq("fill_cnt", {58'h0, a_pend_cnt}, 64'd31);
    a_alloc_en = 1'b1; a_alloc_addr = 5'd5;
    step();
    a_rd_addr = {5'd31, 5'd5};
    #1;
    check_eq("realloc_cnt", {58'h0, a_pend_cnt}, 64'd31);
    check_eq("fill_busy", {62'h0, a_rd_busy}, 64'd3);
    for (int r = 1; r < 32; r++) begin
      a_wr_en = 2'b01; a_wr_addr[4:0] = 5'(r); a_wr_data[31:0] = 32'(r);
      step();
    end
    a_rd_addr = {5'd31, 5'd17};
    #1;
    check_eq("drain_cnt", {58'h0, a_pend_cnt}, 64'h0);
    check_eq("drain_data", a_rd_data, {32'd31, 32'd17});
    check_eq("drain_busy", {62'h0, a_rd_busy}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next-generation KGP_RISC datapath: N_RD asynchronous read ports, N_WR synchronous write ports.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Per-register pending (scoreboard) bits: the issue stage marks a destination pending; the write port that retires it clears the bit. Decode uses rd_busy to stall.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREGS = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- N_WR, 1, number of write ports (1..2)
- ZERO_REG, 1, 1: register 0 always reads 0, ignores writes, never pending
- BYPASS, 1, 1: a read sees same-cycle write data for a matching address

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  N_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  read data, packed likewise
- rd_busy  out  N_RD  pending bit of the addressed register, per read port
- wr_en  in  N_WR  write enable per write port
- wr_addr  in  N_WR*ADDR_W  write addresses
- wr_data  in  N_WR*DATA_W  write data
- alloc_en  in  1  mark alloc_addr pending this edge
- alloc_addr  in  ADDR_W  register to mark pending
- pend_cnt  out  ADDR_W+1  registered count of pending registers

Behaviour:
- Reset (async, immediate):
  - All NREGS registers cleared to 0.
  - All pending bits cleared; pend_cnt = 0.
  - rd_data then reads 0 and rd_busy reads 0.
  - Reset asserted mid-cycle discards any write or alloc in flight.
- Writes:
  - On posedge clk, each port j with wr_en[j]=1 stores wr_data[j] into wr_addr[j].
  - Two ports to the same address in the same cycle: the higher port index wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads (combinational, zero latency):
  - rd_data[i] = register contents at rd_addr[i].
  - ZERO_REG=1 and rd_addr[i]=0: reads 0 regardless of other inputs.
  - BYPASS=1: if any enabled write port targets rd_addr[i] this cycle, rd_data[i] returns that port's wr_data (highest index wins).
  - BYPASS=0: rd_data[i] returns the old value until the edge.
- Pending bits:
  - Set on posedge when alloc_en=1 (ignored for address 0 when ZERO_REG=1).
  - Cleared on posedge for each wr_en[j] address.
  - alloc and write to the same register in the same cycle: set wins (new producer supersedes retiring one).
  - Alloc of an already-pending register: stays set, pend_cnt unchanged.
  - Write to a non-pending register: data written, no pending change.
- rd_busy[i]:
  - Combinational from the pending bits.
  - BYPASS=1: a same-cycle clearing write masks busy to 0 unless a same-cycle alloc also targets that address.
  - ZERO_REG=1 and address 0: always 0.
- pend_cnt:
  - Registered population count of the pending bits; updated on the same edge as the bits.
  - Range 0..NREGS (NREGS only when ZERO_REG=0).
  - No saturation logic is needed because the bit vector bounds it.
- Address width is exact; there is no out-of-range case.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults and a ZERO_ADDR constant, used by decode and issue stages.
- Sub-module rf_scoreboard: pending-bit array, set/clear priority, pend_cnt popcount.
- Data array, write arbitration and bypass muxing stay in regfile_mp.

Test Plan:
- Reset then read: rst pulse, rd_addr={5,31} -> rd_data={0,0}, rd_busy=0, pend_cnt=0; rst asserted between edges clears reg 3 = 0xDEADBEEF immediately.
- Write/read and zero register:
  - wr r7=0x12345678, then read r7 -> 0x12345678.
  - wr r0=0xFFFFFFFF, read r0 -> 0; alloc r0 -> pend_cnt stays 0.
- Bypass, same cycle:
  - BYPASS=1: wr r9=0xA5A5A5A5 while rd_addr=9 -> rd_data=0xA5A5A5A5 before the edge.
  - BYPASS=0: old value 0 before the edge, new value after.
- Dual-write conflict (N_WR=2): port0 r4=0x1111, port1 r4=0x2222 same edge -> r4 reads 0x2222.
- Scoreboard:
  - alloc r10 -> rd_busy=1, pend_cnt=1.
  - wr r10=0x55 -> busy 0, pend_cnt=0.
  - alloc r10 plus wr r10 same edge -> r10=new data, busy stays 1, pend_cnt=1.
- Fill/drain (ZERO_REG=1): alloc r1..r31 over 31 cycles -> pend_cnt=31; re-alloc r5 -> 31; write all back -> pend_cnt=0.
